// File: rtl/pc_stack_pkg.sv
// Shared constants and types for the pc_stack4 program counter / return-address stack.
package pc_stack_pkg;

  localparam int          WIDTH    = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef logic [1:0] ptr_t;
  typedef logic [2:0] depth_t;

  localparam depth_t DEPTH_FULL = 3'(DEPTH);

  // Five operations need three bits.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

endpackage

// File: rtl/pc_stack4_mux.sv
// Team 4-way 16-bit mux cell, used for the top-of-stack read.
module meu_mux4way16
  import pc_stack_pkg::*;
(
  input  logic [WIDTH-1:0] canal_a,
  input  logic [WIDTH-1:0] canal_b,
  input  logic [WIDTH-1:0] canal_c,
  input  logic [WIDTH-1:0] canal_d,
  input  ptr_t             controle_sel,
  output logic [WIDTH-1:0] saida
);

  always_comb begin
    case (controle_sel)
      2'd0:    saida = canal_a;
      2'd1:    saida = canal_b;
      2'd2:    saida = canal_c;
      default: saida = canal_d;
    endcase
  end

endmodule

// File: rtl/pc_stack4.sv
// 16-bit program counter with a 4-entry return-address stack (jump/call/return).
// Define PC_STACK_WRAP_EN for a circular stack that overwrites the oldest entry when full.
module pc_stack4
  import pc_stack_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc_out,
  output depth_t           depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err_ovf,
  output logic             err_unf
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, tos;
  depth_t           depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  ptr_t             wr_ptr, rd_ptr;
  op_e              op;

`ifdef PC_STACK_WRAP_EN
  ptr_t head_q, head_d;
  assign wr_ptr = head_q;
`else
  // Without wrap the write slot is simply the current depth.
  assign wr_ptr = depth_q[1:0];
`endif
  assign rd_ptr = wr_ptr - 2'd1;
  assign pc_inc = pc_q + 16'd1;

  meu_mux4way16 u_tos_mux (
    .canal_a      (entry_q[0]),
    .canal_b      (entry_q[1]),
    .canal_c      (entry_q[2]),
    .canal_d      (entry_q[3]),
    .controle_sel (rd_ptr),
    .saida        (tos)
  );

  always_comb begin
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (load) op = OP_LOAD;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
`ifdef PC_STACK_WRAP_EN
    head_d  = head_q;
`endif
    case (op)
      OP_INC:  pc_d = pc_inc;
      OP_LOAD: pc_d = target;
      OP_CALL: begin
        pc_d = target;
        if (depth_q != DEPTH_FULL) begin
          push    = 1'b1;
          depth_d = depth_q + 3'd1;
        end else begin
`ifdef PC_STACK_WRAP_EN
          push = 1'b1;
`else
          ovf_d = 1'b1;
`endif
        end
`ifdef PC_STACK_WRAP_EN
        head_d = head_q + 2'd1;
`endif
      end
      OP_RET: begin
        // Return on an empty stack behaves as a plain increment.
        if (depth_q == 3'd0) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d    = tos;
          depth_d = depth_q - 3'd1;
`ifdef PC_STACK_WRAP_EN
          head_d  = head_q - 2'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef PC_STACK_WRAP_EN
      head_q  <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef PC_STACK_WRAP_EN
      head_q  <= head_d;
`endif
    end
  end

  // Entry storage carries no reset; an emptied stack makes its contents irrelevant.
  always_ff @(posedge clk) begin
    if (push && !reset) entry_q[wr_ptr] <= pc_inc;
  end

  assign pc_out      = pc_q;
  assign depth       = depth_q;
  assign stack_full  = (depth_q == DEPTH_FULL);
  assign stack_empty = (depth_q == 3'd0);
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;

endmodule

// File: tb/tb_pc_stack4.sv
// Self-checking bench for pc_stack4: queue-based reference model, directed plan and random ops.
module tb_pc_stack4;

  logic        clk = 1'b0;
  logic        reset, inc, load, call, ret;
  logic [15:0] target;
  logic [15:0] pc_out;
  logic [2:0]  depth;
  logic        stack_full, stack_empty, err_ovf, err_unf;

  always #5 clk = ~clk;

  pc_stack4 dut (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc),
    .load        (load),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc_out      (pc_out),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_pc;
  logic [15:0] m_stk [$];
  logic        m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic i, input logic l,
                              input logic c, input logic rt, input logic [15:0] t);
    logic [15:0] nxt;
    nxt = m_pc + 16'd1;
    if (r) begin
      m_pc = 16'h0000;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (rt) begin
      if (m_stk.size() == 0) begin
        m_pc  = nxt;
        m_unf = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (c) begin
`ifdef PC_STACK_WRAP_EN
      if (m_stk.size() == 4) void'(m_stk.pop_front());
      m_stk.push_back(nxt);
`else
      if (m_stk.size() < 4) m_stk.push_back(nxt);
      else m_ovf = 1'b1;
`endif
      m_pc = t;
    end else if (l) begin
      m_pc = t;
    end else if (i) begin
      m_pc = nxt;
    end
  endtask

  task automatic compare();
    chk("pc_out",      32'(pc_out),      32'(m_pc));
    chk("depth",       32'(depth),       32'(m_stk.size()));
    chk("stack_full",  32'(stack_full),  32'(m_stk.size() == 4));
    chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
    chk("err_ovf",     32'(err_ovf),     32'(m_ovf));
    chk("err_unf",     32'(err_unf),     32'(m_unf));
  endtask

  task automatic step(input logic r, input logic i, input logic l,
                      input logic c, input logic rt, input logic [15:0] t);
    reset = r; inc = i; load = l; call = c; ret = rt; target = t;
    @(posedge clk);
    model_update(r, i, l, c, rt, t);
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);

    // Reset and increments
    step(1, 0, 0, 0, 0, 16'h0);
    chk("rst_pc", 32'(pc_out), 32'h0000);
    chk("rst_empty", 32'(stack_empty), 32'h1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 16'h0);
    chk("inc3_pc", 32'(pc_out), 32'h0003);
    chk("inc3_depth", 32'(depth), 32'h0);

    // Call / return round trip
    step(0, 0, 1, 0, 0, 16'h0010);
    step(0, 0, 0, 1, 0, 16'h0100);
    chk("call_pc", 32'(pc_out), 32'h0100);
    chk("call_depth", 32'(depth), 32'h1);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("ret_pc", 32'(pc_out), 32'h0011);
    chk("ret_depth", 32'(depth), 32'h0);

    // Five calls: overflow or wrap
    step(1, 0, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 1, 0, 16'(k * 16'h1000));
      if (k == 4) chk("full4", 32'(stack_full), 32'h1);
    end
    chk("call5_pc", 32'(pc_out), 32'h5000);
    chk("call5_depth", 32'(depth), 32'h4);
`ifdef PC_STACK_WRAP_EN
    chk("call5_ovf", 32'(err_ovf), 32'h0);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo1", 32'(pc_out), 32'h4001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo2", 32'(pc_out), 32'h3001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo3", 32'(pc_out), 32'h2001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo4", 32'(pc_out), 32'h1001);
`else
    chk("call5_ovf", 32'(err_ovf), 32'h1);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo1", 32'(pc_out), 32'h3001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo2", 32'(pc_out), 32'h2001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo3", 32'(pc_out), 32'h1001);
    step(0, 0, 0, 0, 1, 16'h0); chk("lifo4", 32'(pc_out), 32'h0001);
`endif

    // Underflow and sticky flag
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0020);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("unf_pc", 32'(pc_out), 32'h0021);
    chk("unf_flag", 32'(err_unf), 32'h1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 16'h0);
    chk("unf_sticky", 32'(err_unf), 32'h1);
    chk("unf_depth", 32'(depth), 32'h0);

    // Wrap-around of PC+1
    step(0, 0, 1, 0, 0, 16'hFFFF);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("wrap_inc", 32'(pc_out), 32'h0000);
    step(0, 0, 1, 0, 0, 16'hFFFF);
    step(0, 0, 0, 1, 0, 16'h0200);
    chk("wrap_call", 32'(pc_out), 32'h0200);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("wrap_ret", 32'(pc_out), 32'h0000);

    // Priority: ret beats call and load; reset beats call
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0005);
    step(0, 0, 0, 1, 0, 16'h0010);
    step(0, 0, 0, 1, 0, 16'h0020);
    step(0, 0, 1, 1, 1, 16'h0099);
    chk("prio_pc", 32'(pc_out), 32'h0011);
    chk("prio_depth", 32'(depth), 32'h1);
    step(0, 0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);
    chk("prio_unf", 32'(err_unf), 32'h1);
    step(1, 0, 0, 1, 0, 16'h0300);
    chk("rstcall_pc", 32'(pc_out), 32'h0000);
    chk("rstcall_depth", 32'(depth), 32'h0);
    chk("rstcall_unf", 32'(err_unf), 32'h0);

    // Random operations
    for (int n = 0; n < 2000; n++) begin
      logic        r, i, l, c, rt;
      logic [15:0] t;
      r  = ($urandom_range(63) == 0);
      i  = ($urandom_range(2) == 0);
      l  = ($urandom_range(4) == 0);
      c  = ($urandom_range(2) == 0);
      rt = ($urandom_range(2) == 0);
      t  = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, i, l, c, rt, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
